// File: rtl/corr_pkt_rx_if.sv
// Byte-pipe input and parallel-record output bundle of the correlator packet receiver.
// The slave modport is the receiver; the master modport is the byte source and record consumer.
interface corr_pkt_rx_if;
  logic [7:0] i_bp_data;
  logic       i_bp_valid;
  logic       o_bp_ready;
  logic [7:0] o_winNum;
  logic [7:0] o_countX;
  logic [7:0] o_countY;
  logic [7:0] o_countIsect;
  logic [7:0] o_countSymdiff;
  logic       o_pkt_valid;
  logic       i_pkt_ready;
  logic       o_seqErr;
  logic [7:0] o_nDropped;
  logic       o_timeout;

  modport slave (
    input  i_bp_data, i_bp_valid, i_pkt_ready,
    output o_bp_ready, o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff,
           o_pkt_valid, o_seqErr, o_nDropped, o_timeout
  );

  modport master (
    output i_bp_data, i_bp_valid, i_pkt_ready,
    input  o_bp_ready, o_winNum, o_countX, o_countY, o_countIsect, o_countSymdiff,
           o_pkt_valid, o_seqErr, o_nDropped, o_timeout
  );
endinterface

// File: rtl/corr_pkt_rx.sv
// Reassembles 5-byte correlator window packets into a parallel record and tracks winNum continuity.
// Optional mid-packet idle timeout enabled by defining CORR_PKT_RX_TIMEOUT_EN.
module corr_pkt_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cg,
  input  logic        i_resync,
  corr_pkt_rx_if.slave bus
);

  typedef enum logic [2:0] {B0, B1, B2, B3, B4, HOLD} state_t;

  state_t     state;
  logic [7:0] winNum, countX, countY, countIsect, countSymdiff;
  logic [7:0] nDropped, expected;
  logic       seqErr, seqKnown, timeout;
  logic       bpReady, accept, tmoHit;
  logic [8:0] dropSum;

  assign bpReady = i_rst && i_cg && (state != HOLD);
  // ready stays as advertised during resync, but the byte is still discarded
  assign accept  = bus.i_bp_valid && bpReady && !i_resync;
  assign dropSum = {1'b0, nDropped} + {1'b0, winNum - expected};

`ifdef CORR_PKT_RX_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TmoW-1:0] tmoCnt;

  assign tmoHit = (state inside {B1, B2, B3, B4}) && !accept &&
                  (tmoCnt == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      tmoCnt <= '0;
    end else if (i_cg) begin
      if (i_resync || accept || tmoHit || state == B0 || state == HOLD)
        tmoCnt <= '0;
      else
        tmoCnt <= tmoCnt + 1'b1;
    end
  end
`else
  logic unusedTmo;
  assign unusedTmo = (TIMEOUT_CYCLES == 0);
  assign tmoHit    = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state        <= B0;
      winNum       <= '0;
      countX       <= '0;
      countY       <= '0;
      countIsect   <= '0;
      countSymdiff <= '0;
      nDropped     <= '0;
      expected     <= '0;
      seqErr       <= 1'b0;
      seqKnown     <= 1'b0;
      timeout      <= 1'b0;
    end else if (i_cg) begin
      seqErr  <= 1'b0;
      timeout <= 1'b0;
      if (i_resync) begin
        state    <= B0;
        seqKnown <= 1'b0;
      end else if (tmoHit) begin
        state    <= B0;
        seqKnown <= 1'b0;
        timeout  <= 1'b1;
      end else begin
        case (state)
          B0: if (accept) begin winNum     <= bus.i_bp_data; state <= B1; end
          B1: if (accept) begin countX     <= bus.i_bp_data; state <= B2; end
          B2: if (accept) begin countY     <= bus.i_bp_data; state <= B3; end
          B3: if (accept) begin countIsect <= bus.i_bp_data; state <= B4; end
          B4: if (accept) begin
            countSymdiff <= bus.i_bp_data;
            state        <= HOLD;
            expected     <= winNum + 8'd1;
            seqKnown     <= 1'b1;
            // gap counted modulo 256, accumulator saturates at 255
            if (seqKnown && winNum != expected) begin
              seqErr   <= 1'b1;
              nDropped <= dropSum[8] ? 8'hFF : dropSum[7:0];
            end
          end
          HOLD: if (bus.i_pkt_ready) state <= B0;
          default: state <= B0;
        endcase
      end
    end
  end

  assign bus.o_bp_ready     = bpReady;
  assign bus.o_winNum       = winNum;
  assign bus.o_countX       = countX;
  assign bus.o_countY       = countY;
  assign bus.o_countIsect   = countIsect;
  assign bus.o_countSymdiff = countSymdiff;
  assign bus.o_pkt_valid    = (state == HOLD);
  assign bus.o_seqErr       = seqErr;
  assign bus.o_nDropped     = nDropped;
  assign bus.o_timeout      = timeout;

endmodule

// File: tb/tb_corr_pkt_rx.sv
// Directed bench for corr_pkt_rx: a packet table for sequence tracking plus hand sequences
// for backpressure, reset, resync, clock gating and the idle timeout.
module tb_corr_pkt_rx;

  logic clk = 1'b0;
  logic rst;
  logic cg;
  logic resync;
  int   total = 0;
  int   bad   = 0;

  corr_pkt_rx_if bpIf();

  corr_pkt_rx #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_cg     (cg),
    .i_resync (resync),
    .bus      (bpIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] pkt;
    logic        expErr;
    logic [7:0]  expDrop;
  } pktVec_t;

  pktVec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] fields();
    return {bpIf.o_winNum, bpIf.o_countX, bpIf.o_countY, bpIf.o_countIsect, bpIf.o_countSymdiff};
  endfunction

  task automatic feedByte(input logic [7:0] d);
    bpIf.i_bp_valid = 1'b1;
    bpIf.i_bp_data  = d;
    #1;
    chk("bp_ready before accept", 64'(bpIf.o_bp_ready), 64'd1);
    tick();
    bpIf.i_bp_valid = 1'b0;
  endtask

  task automatic checkHold(input logic [39:0] p, input logic e, input logic [7:0] dr);
    chk("pkt_valid first hold", 64'(bpIf.o_pkt_valid), 64'd1);
    chk("fields", 64'(fields()), 64'(p));
    chk("seqErr first hold", 64'(bpIf.o_seqErr), 64'(e));
    chk("nDropped", 64'(bpIf.o_nDropped), 64'(dr));
    chk("bp_ready in hold", 64'(bpIf.o_bp_ready), 64'd0);
  endtask

  task automatic streamPkt(input logic [39:0] p, input logic e, input logic [7:0] dr);
    for (int unsigned i = 0; i < 5; i++) begin
      feedByte(p[39 - 8*i -: 8]);
      if (i < 4) chk("pkt_valid early", 64'(bpIf.o_pkt_valid), 64'd0);
    end
    checkHold(p, e, dr);
  endtask

  task automatic releasePkt(input logic [39:0] p);
    tick();
    chk("seqErr second hold", 64'(bpIf.o_seqErr), 64'd0);
    chk("pkt_valid second hold", 64'(bpIf.o_pkt_valid), 64'd1);
    chk("fields stable", 64'(fields()), 64'(p));
    bpIf.i_pkt_ready = 1'b1;
    tick();
    chk("pkt_valid after release", 64'(bpIf.o_pkt_valid), 64'd0);
    chk("bp_ready after release", 64'(bpIf.o_bp_ready), 64'd1);
    bpIf.i_pkt_ready = 1'b0;
  endtask

  task automatic sendPkt(input logic [39:0] p, input logic e, input logic [7:0] dr);
    streamPkt(p, e, dr);
    releasePkt(p);
  endtask

  task automatic checkAllZero(input string nm);
    chk(nm, {11'd0, bpIf.o_bp_ready, bpIf.o_pkt_valid, fields(), bpIf.o_seqErr,
             bpIf.o_nDropped, bpIf.o_timeout}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{40'h05_10_20_30_40, 1'b0, 8'h00};
    tbl[1] = '{40'h08_11_22_33_44, 1'b1, 8'h02};
    tbl[2] = '{40'hFF_01_02_03_04, 1'b1, 8'hF8};
    tbl[3] = '{40'h00_A1_A2_A3_A4, 1'b0, 8'hF8};
    tbl[4] = '{40'h10_B1_B2_B3_B4, 1'b1, 8'hFF};
    tbl[5] = '{40'h20_C1_C2_C3_C4, 1'b1, 8'hFF};
    tbl[6] = '{40'h21_D1_D2_D3_D4, 1'b0, 8'hFF};

    rst = 1'b0; cg = 1'b1; resync = 1'b0;
    bpIf.i_bp_valid = 1'b0; bpIf.i_bp_data = '0; bpIf.i_pkt_ready = 1'b0;
    tick(); tick();
    checkAllZero("reset state");
    rst = 1'b1;
    tick();

    for (int unsigned i = 0; i < 7; i++)
      sendPkt(tbl[i].pkt, tbl[i].expErr, tbl[i].expDrop);

    // backpressure: source keeps offering while the record is held
    streamPkt(40'h22_E1_E2_E3_E4, 1'b0, 8'hFF);
    bpIf.i_bp_valid = 1'b1; bpIf.i_bp_data = 8'hEE;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready backpressure", 64'(bpIf.o_bp_ready), 64'd0);
      chk("fields backpressure", 64'(fields()), 64'h22_E1_E2_E3_E4);
    end
    bpIf.i_bp_valid = 1'b0;
    releasePkt(40'h22_E1_E2_E3_E4);
    sendPkt(40'h23_F1_F2_F3_F4, 1'b0, 8'hFF);

    // reset mid-packet
    feedByte(8'h24); feedByte(8'h01); feedByte(8'h02);
    rst = 1'b0;
    tick();
    checkAllZero("reset mid-packet");
    rst = 1'b1;
    sendPkt(40'h77_01_02_03_04, 1'b0, 8'h00);

    // resync while holding a record
    streamPkt(40'h10_11_12_13_14, 1'b1, 8'h98);
    resync = 1'b1; bpIf.i_bp_valid = 1'b1; bpIf.i_bp_data = 8'h77;
    tick();
    chk("pkt_valid after resync", 64'(bpIf.o_pkt_valid), 64'd0);
    resync = 1'b0; bpIf.i_bp_valid = 1'b0;
    sendPkt(40'h50_5A_5B_5C_5D, 1'b0, 8'h98);

    // resync mid-packet, offered byte must be dropped
    feedByte(8'h51); feedByte(8'h52);
    resync = 1'b1; bpIf.i_bp_valid = 1'b1; bpIf.i_bp_data = 8'h99;
    tick();
    resync = 1'b0; bpIf.i_bp_valid = 1'b0;
    chk("pkt_valid mid resync", 64'(bpIf.o_pkt_valid), 64'd0);
    sendPkt(40'h60_61_62_63_64, 1'b0, 8'h98);

    // clock gate freezes mid-packet
    feedByte(8'h61); feedByte(8'hAB);
    cg = 1'b0; bpIf.i_bp_valid = 1'b1; bpIf.i_bp_data = 8'hAA;
    #1;
    chk("bp_ready gated", 64'(bpIf.o_bp_ready), 64'd0);
    tick(); tick();
    chk("winNum gated", 64'(bpIf.o_winNum), 64'h61);
    cg = 1'b1; bpIf.i_bp_valid = 1'b0;
    feedByte(8'hCD); feedByte(8'hEF); feedByte(8'h12);
    checkHold(40'h61_AB_CD_EF_12, 1'b0, 8'h98);
    releasePkt(40'h61_AB_CD_EF_12);

    // idle mid-packet
    feedByte(8'h62); feedByte(8'h33);
    repeat (15) tick();
    chk("timeout before limit", 64'(bpIf.o_timeout), 64'd0);
    chk("bp_ready before limit", 64'(bpIf.o_bp_ready), 64'd1);
    tick();
`ifdef CORR_PKT_RX_TIMEOUT_EN
    chk("timeout pulse", 64'(bpIf.o_timeout), 64'd1);
    tick();
    chk("timeout pulse end", 64'(bpIf.o_timeout), 64'd0);
    sendPkt(40'h90_91_92_93_94, 1'b0, 8'h98);
`else
    chk("timeout tied low", 64'(bpIf.o_timeout), 64'd0);
    feedByte(8'h44); feedByte(8'h55); feedByte(8'h66);
    checkHold(40'h62_33_44_55_66, 1'b0, 8'h98);
    releasePkt(40'h62_33_44_55_66);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
